// File: rtl/flash_op_sequencer.sv
// flash_op_sequencer: expands one NAND request (read/program/erase/reset)
// into a timed stream of 8-bit micro-ops and watches the selected die's rb.
// Ports: clock_100/rst (sync, active-high); req_valid/req_ready/req_op/
// req_chip/req_addr request side; cmd/addr_byte/ce micro-op side;
// rb1_ctrl/rb2_ctrl die ready/busy; done/err completion report.
module flash_op_sequencer #(
    parameter int unsigned CMD_HOLD       = 4,
    parameter int unsigned XFER_CYCLES    = 2048,
    parameter int unsigned TWB_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic        clock_100,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic        req_chip,
    input  logic [39:0] req_addr,
    output logic [7:0]  cmd,
    output logic [7:0]  addr_byte,
    output logic        ce,
    input  logic        rb1_ctrl,
    input  logic        rb2_ctrl,
    output logic        done,
    output logic        err
);

    localparam int unsigned CNT_W = 21;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DATA, S_WBUSY, S_WREADY, S_DONE
    } state_e;

    typedef struct packed {
        state_e     st;
        logic [4:0] idx;
    } step_t;

    state_e             state_q, state_d;
    logic [3:0]         step_q, step_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic               chip_q, chip_d;
    logic [39:0]        addr_q, addr_d;
    logic               err_q, err_d;
    logic               advance;
    logic               rb;
    step_t              cur;

    // Per-op micro-op list; anything past the end of a list is DONE.
    function automatic step_t step_at(input logic [1:0] op, input logic [3:0] s);
        step_t r;
        r.st  = S_DONE;
        r.idx = 5'd0;
        unique case (op)
            2'd0: begin
                if (s == 4'd0) begin r.st = S_CMD; r.idx = 5'd0; end
                else if (s <= 4'd5) begin r.st = S_ADDR; r.idx = {1'b0, s - 4'd1}; end
                else if (s == 4'd6) begin r.st = S_CMD; r.idx = 5'd1; end
                else if (s == 4'd7) r.st = S_WBUSY;
                else if (s == 4'd8) r.st = S_WREADY;
                else if (s == 4'd9) begin r.st = S_DATA; r.idx = 5'd0; end
            end
            2'd1: begin
                if (s == 4'd0) begin r.st = S_CMD; r.idx = 5'd2; end
                else if (s <= 4'd5) begin r.st = S_ADDR; r.idx = {1'b0, s - 4'd1}; end
                else if (s == 4'd6) begin r.st = S_DATA; r.idx = 5'd1; end
                else if (s == 4'd7) begin r.st = S_CMD; r.idx = 5'd3; end
                else if (s == 4'd8) r.st = S_WBUSY;
                else if (s == 4'd9) r.st = S_WREADY;
            end
            2'd2: begin
                if (s == 4'd0) begin r.st = S_CMD; r.idx = 5'd4; end
                else if (s <= 4'd3) begin r.st = S_ADDR; r.idx = {1'b0, s + 4'd1}; end
                else if (s == 4'd4) begin r.st = S_CMD; r.idx = 5'd5; end
                else if (s == 4'd5) r.st = S_WBUSY;
                else if (s == 4'd6) r.st = S_WREADY;
            end
            2'd3: begin
                if (s == 4'd0) begin r.st = S_CMD; r.idx = 5'd6; end
                else if (s == 4'd1) r.st = S_WBUSY;
                else if (s == 4'd2) r.st = S_WREADY;
            end
        endcase
        return r;
    endfunction

    assign cur = step_at(op_q, step_q);
    assign rb  = chip_q ? rb2_ctrl : rb1_ctrl;

    always_ff @(posedge clock_100) begin
        if (rst) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            chip_q  <= 1'b0;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            chip_q  <= chip_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q + CNT_W'(1);
        op_d    = op_q;
        chip_d  = chip_q;
        addr_d  = addr_q;
        err_d   = err_q;
        advance = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (req_valid) begin
                    op_d    = req_op;
                    chip_d  = req_chip;
                    addr_d  = req_addr;
                    err_d   = 1'b0;
                    step_d  = '0;
                    state_d = S_CMD;
                end
            end
            S_CMD, S_ADDR: begin
                if (cnt_q == CNT_W'(CMD_HOLD - 1)) advance = 1'b1;
            end
            S_DATA: begin
                if (cnt_q == CNT_W'(XFER_CYCLES - 1)) advance = 1'b1;
            end
            S_WBUSY: begin
                // A die that never drops rb is treated as already finished.
                if (!rb || cnt_q == CNT_W'(TWB_CYCLES - 1)) advance = 1'b1;
            end
            S_WREADY: begin
                if (rb) begin
                    advance = 1'b1;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Jump straight to DONE so a read skips its data burst.
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                step_d  = '0;
                cnt_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
        if (advance) begin
            step_d  = step_q + 4'd1;
            state_d = step_at(op_q, step_q + 4'd1).st;
            cnt_d   = '0;
        end
    end

    always_comb begin
        cmd       = 8'h00;
        addr_byte = 8'h00;
        unique case (state_q)
            S_CMD:  cmd = {2'b01, chip_q, cur.idx};
            S_ADDR: begin
                cmd       = {2'b10, chip_q, cur.idx};
                addr_byte = 8'(addr_q >> {cur.idx[2:0], 3'b000});
            end
            S_DATA: cmd = {2'b11, chip_q, cur.idx};
            default: cmd = 8'h00;
        endcase
    end

    assign req_ready = (state_q == S_IDLE);
    assign ce        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign err       = done & err_q;

endmodule

// File: tb/tb_flash_op_sequencer.sv
// tb_flash_op_sequencer: table vectors, hand sequences and random ops
// checked cycle-by-cycle against a micro-op list model of the sequencer.
module tb_flash_op_sequencer;

    localparam int HOLD = 4;
    localparam int XFER = 8;
    localparam int TWB  = 16;
    localparam int TO   = 64;

    logic        clock_100 = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic        req_chip = 1'b0;
    logic [39:0] req_addr = '0;
    logic [7:0]  cmd;
    logic [7:0]  addr_byte;
    logic        ce;
    logic        rb1_ctrl = 1'b1;
    logic        rb2_ctrl = 1'b1;
    logic        done;
    logic        err;

    int checks = 0;
    int failures = 0;

    flash_op_sequencer #(
        .CMD_HOLD(HOLD), .XFER_CYCLES(XFER),
        .TWB_CYCLES(TWB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock_100(clock_100), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_chip(req_chip), .req_addr(req_addr),
        .cmd(cmd), .addr_byte(addr_byte), .ce(ce),
        .rb1_ctrl(rb1_ctrl), .rb2_ctrl(rb2_ctrl),
        .done(done), .err(err)
    );

    always #5 clock_100 = ~clock_100;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] ab;
        logic       ce;
        logic       done;
        logic       err;
        logic       rb;
    } cyc_t;

    typedef struct {
        logic [1:0]  op;
        logic        chip;
        logic [39:0] addr;
        int          f;
        int          r;
        int          exp_len;
        logic        exp_err;
    } vec_t;

    cyc_t exp_q[$];
    vec_t tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock_100);
        #1;
    endtask

    function automatic void push(logic [7:0] c, logic [7:0] ab, int n, logic rbv);
        cyc_t e;
        e.cmd = c; e.ab = ab; e.ce = 1'b1;
        e.done = 1'b0; e.err = 1'b0; e.rb = rbv;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endfunction

    // f: cycles rb stays high into the busy wait; r: cycles rb stays low
    // into the ready wait (r >= TO means the die never recovers).
    function automatic void build(logic [1:0] op, logic chip, logic [39:0] addr, int f, int r);
        logic [7:0] c;
        logic [7:0] b8;
        int   wb;
        int   wr;
        bit   to;
        cyc_t e;
        c = {2'b00, chip, 5'd0};
        exp_q.delete();
        case (op)
            2'd0: begin
                push(8'h40 | c, 8'h00, HOLD, 1'b1);
                for (int b = 0; b < 5; b++) begin
                    b8 = 8'(b);
                    push(8'h80 | c | b8, addr[8*b +: 8], HOLD, 1'b1);
                end
                push(8'h41 | c, 8'h00, HOLD, 1'b1);
            end
            2'd1: begin
                push(8'h42 | c, 8'h00, HOLD, 1'b1);
                for (int b = 0; b < 5; b++) begin
                    b8 = 8'(b);
                    push(8'h80 | c | b8, addr[8*b +: 8], HOLD, 1'b1);
                end
                push(8'hC1 | c, 8'h00, XFER, 1'b1);
                push(8'h43 | c, 8'h00, HOLD, 1'b1);
            end
            2'd2: begin
                push(8'h44 | c, 8'h00, HOLD, 1'b1);
                for (int b = 2; b < 5; b++) begin
                    b8 = 8'(b);
                    push(8'h80 | c | b8, addr[8*b +: 8], HOLD, 1'b1);
                end
                push(8'h45 | c, 8'h00, HOLD, 1'b1);
            end
            default: push(8'h46 | c, 8'h00, HOLD, 1'b1);
        endcase
        wb = (f < TWB) ? f + 1 : TWB;
        for (int j = 0; j < wb; j++) push(8'h00, 8'h00, 1, (j < f));
        to = (r >= TO);
        wr = to ? TO : r + 1;
        for (int j = 0; j < wr; j++) push(8'h00, 8'h00, 1, (j >= r));
        if (op == 2'd0 && !to) push(8'hC0 | c, 8'h00, XFER, 1'b1);
        e.cmd = 8'h00; e.ab = 8'h00; e.ce = 1'b0;
        e.done = 1'b1; e.err = to; e.rb = 1'b1;
        exp_q.push_back(e);
    endfunction

    task automatic run_op(input logic [1:0] op, input logic chip, input logic [39:0] addr,
                          input int f, input int r, input bit noise,
                          output int done_at, output logic err_seen);
        cyc_t e;
        int   n;
        build(op, chip, addr, f, r);
        n = exp_q.size();
        check("ready_before_accept", 64'(req_ready), 64'(1));
        req_valid = 1'b1;
        req_op    = op;
        req_chip  = chip;
        req_addr  = addr;
        tick();
        done_at  = -1;
        err_seen = 1'b0;
        for (int k = 0; k < n; k++) begin
            e = exp_q[k];
            req_valid = (noise && k < n - 1) ? 1'($urandom) : 1'b0;
            req_op    = 2'($urandom);
            req_chip  = 1'($urandom);
            req_addr  = {8'($urandom), 32'($urandom)};
            if (chip) begin
                rb2_ctrl = e.rb;
                rb1_ctrl = 1'($urandom);
            end else begin
                rb1_ctrl = e.rb;
                rb2_ctrl = 1'($urandom);
            end
            check($sformatf("cycle op=%0d k=%0d {cmd,ab,ce,done,err,rdy}", op, k),
                  64'({cmd, addr_byte, ce, done, err, req_ready}),
                  64'({e.cmd, e.ab, e.ce, e.done, e.err, 1'b0}));
            if (done && done_at < 0) begin
                done_at  = k + 1;
                err_seen = err;
            end
            tick();
        end
        req_valid = 1'b0;
        rb1_ctrl  = 1'b1;
        rb2_ctrl  = 1'b1;
        check("idle_after_done {rdy,ce,done,cmd}",
              64'({req_ready, ce, done, cmd}), 64'({1'b1, 1'b0, 1'b0, 8'h00}));
    endtask

    initial begin
        int   d;
        logic e;
        int   seen_done;

        tbl[0] = '{2'd0, 1'b0, 40'h04_0302_0100, 5, 19, 63, 1'b0};
        tbl[1] = '{2'd1, 1'b1, 40'h55_4433_2211, 3, 10, 52, 1'b0};
        tbl[2] = '{2'd2, 1'b0, 40'h9A_BCDE_F012, 2, 5, 30, 1'b0};
        tbl[3] = '{2'd2, 1'b0, 40'h01_0203_0405, 1, 100, 87, 1'b1};
        tbl[4] = '{2'd3, 1'b1, 40'h00_0000_0000, 99, 0, 22, 1'b0};
        tbl[5] = '{2'd0, 1'b1, 40'hA5_5AA5_5AA5, 0, 64, 94, 1'b1};
        tbl[6] = '{2'd3, 1'b0, 40'h00_0000_0000, 0, 63, 70, 1'b0};
        tbl[7] = '{2'd3, 1'b1, 40'h00_0000_0000, 15, 0, 22, 1'b0};

        rst = 1'b1;
        tick();
        tick();
        check("reset {cmd,ab,ce,done,err,rdy}",
              64'({cmd, addr_byte, ce, done, err, req_ready}),
              64'({8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}));
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].op, tbl[i].chip, tbl[i].addr, tbl[i].f, tbl[i].r, 1'b1, d, e);
            check($sformatf("vec%0d latency", i), 64'(d), 64'(tbl[i].exp_len));
            check($sformatf("vec%0d err", i), 64'(e), 64'(tbl[i].exp_err));
        end

        // Reset in the middle of the first address byte of a read.
        req_valid = 1'b1;
        req_op    = 2'd0;
        req_chip  = 1'b0;
        req_addr  = 40'h11_2233_4455;
        tick();
        req_valid = 1'b0;
        repeat (5) tick();
        check("mid_read addr0 {cmd,ab}", 64'({cmd, addr_byte}), 64'({8'h80, 8'h55}));
        rst = 1'b1;
        tick();
        check("after_rst {cmd,ce,rdy,done}",
              64'({cmd, ce, req_ready, done}), 64'({8'h00, 1'b0, 1'b1, 1'b0}));
        rst = 1'b0;
        seen_done = 0;
        for (int k = 0; k < 100; k++) begin
            if (done || ce) seen_done++;
            tick();
        end
        check("no_done_after_rst", 64'(seen_done), 64'(0));
        run_op(2'd0, 1'b0, 40'h0F_0E0D_0C0B, 4, 7, 1'b0, d, e);
        check("post_rst read latency", 64'(d), 64'(28 + 5 + 8 + 8 + 1));

        for (int i = 0; i < 25; i++) begin
            logic [1:0]  rop;
            logic        rch;
            logic [39:0] rad;
            int          rf;
            int          rr;
            rop = 2'($urandom);
            rch = 1'($urandom);
            rad = {8'($urandom), 32'($urandom)};
            rf  = int'($urandom_range(0, 20));
            rr  = int'($urandom_range(0, 70));
            run_op(rop, rch, rad, rf, rr, 1'b1, d, e);
            check($sformatf("rand%0d err", i), 64'(e), 64'(rr >= TO));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
